// File: rtl/sram_req_ctrl_pkg.sv
// Shared constants for sram_req_ctrl: state encodings, default widths, depth helper.
// SRAM_REQ_CTRL_INIT_EN selects the post-reset init sweep.
package sram_req_ctrl_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_RDCAP = 3'd3;
    localparam logic [2:0] S_INIT  = 3'd4;

`ifdef SRAM_REQ_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for the 16x8 single-port SRAM; owns bus direction.
// Define SRAM_REQ_CTRL_INIT_EN to fill the SRAM with INIT_VALUE after every reset.
module sram_req_ctrl
    import sram_req_ctrl_pkg::*;
#(
    parameter int              AW         = AW_DEF,
    parameter int              DW         = DW_DEF,
    parameter logic [DW-1:0]   INIT_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          sram_w_r,
    output logic [AW-1:0] sram_addr,
    inout  wire  [DW-1:0] sram_data
);

    // In the init build the write-data latch doubles as the fill pattern.
    localparam logic [DW-1:0] WDATA_RST = INIT_EN ? INIT_VALUE : '0;
    localparam logic [2:0]    STATE_RST = INIT_EN ? S_INIT : S_IDLE;
`ifdef SRAM_REQ_CTRL_INIT_EN
    localparam int DEPTH = depth_of(AW);
`endif

    logic [2:0]    state;
    logic [DW-1:0] wdata_q;

    assign req_ready = (state == S_IDLE);

    // Drive only while the registered strobe says write: the SRAM drives exactly when it is low.
    assign sram_data = sram_w_r ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= STATE_RST;
            sram_w_r  <= INIT_EN;
            sram_addr <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wdata_q   <= WDATA_RST;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        sram_addr <= req_addr;
                        wdata_q   <= req_wdata;
                        if (req_we) begin
                            sram_w_r <= 1'b1;
                            state    <= S_WR;
                        end else begin
                            state    <= S_RD;
                        end
                    end
                end
                S_WR: begin
                    sram_w_r <= 1'b0;
                    state    <= S_IDLE;
                end
                S_RD: begin
                    state <= S_RDCAP;
                end
                S_RDCAP: begin
                    rsp_rdata <= sram_data;
                    rsp_valid <= 1'b1;
                    state     <= S_IDLE;
                end
`ifdef SRAM_REQ_CTRL_INIT_EN
                S_INIT: begin
                    if (sram_addr == AW'(DEPTH - 1)) begin
                        sram_w_r <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        sram_addr <= sram_addr + 1'b1;
                    end
                end
`endif
                default: begin
                    sram_w_r <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural 16x8 registered-read SRAM on the shared bus.
// Built with SRAM_REQ_CTRL_INIT_EN it checks the init sweep instead of the request sequences.
module tb_sram_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       sram_w_r;
    logic [3:0] sram_addr;
    wire  [7:0] sram_data;

    int vectors     = 0;
    int miscompares = 0;
    int rsp_cnt     = 0;
    int exp_rsp     = 0;
    int bus_bad     = 0;
    bit mon_en      = 1'b0;

    sram_req_ctrl #(.AW(4), .DW(8), .INIT_VALUE(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .sram_w_r  (sram_w_r),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    always #5 clk = ~clk;

    // SRAM model: writes when w_r=1, otherwise registers mem[addr] and drives it.
    logic [7:0] mem [16];
    logic [7:0] q = 8'h00;
    always @(posedge clk) begin
        if (sram_w_r) mem[sram_addr] <= sram_data;
        else          q <= mem[sram_addr];
    end
    assign sram_data = sram_w_r ? 8'hzz : q;

    always @(negedge clk) begin
        if (mon_en && $isunknown(sram_data)) bus_bad++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        step();
        req_valid = 1'b0;
        chk("wr_ready_low", req_ready, 1'b0);
        chk("wr_strobe",    sram_w_r, 1'b1);
        chk("wr_addr",      sram_addr, a);
        chk("wr_bus",       sram_data, d);
        step();
        chk("wr_done_ready", req_ready, 1'b1);
        chk("wr_done_strobe", sram_w_r, 1'b0);
        chk("wr_mem",       mem[a], d);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
        step();
        req_valid = 1'b0;
        chk("rd_ready_low", req_ready, 1'b0);
        chk("rd_strobe",    sram_w_r, 1'b0);
        chk("rd_addr",      sram_addr, a);
        chk("rd_rsp_early", rsp_valid, 1'b0);
        step();
        chk("rdcap_ready_low", req_ready, 1'b0);
        chk("rdcap_rsp_early", rsp_valid, 1'b0);
        step();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rdata",     rsp_rdata, exp);
        chk("rd_ready_back", req_ready, 1'b1);
        step();
        chk("rd_rsp_pulse", rsp_valid, 1'b0);
        exp_rsp++;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h80 + 8'(i);
        step();
        step();
        mon_en = 1'b1;
`ifdef SRAM_REQ_CTRL_INIT_EN
        chk("init_ready", req_ready, 1'b0);
        chk("init_strobe", sram_w_r, 1'b1);
        chk("init_addr0", sram_addr, 4'd0);
        chk("init_bus", sram_data, 8'hFF);
        rst = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            chk("init_ready_low", req_ready, 1'b0);
            chk("init_addr", sram_addr, k);
        end
        step();
        chk("init_done_ready", req_ready, 1'b1);
        chk("init_done_strobe", sram_w_r, 1'b0);
        for (int a = 0; a < 16; a++) do_read(4'(a), 8'hFF);
`else
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_strobe", sram_w_r, 1'b0);
        chk("rst_addr", sram_addr, 4'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        rst = 1'b0;

        // basic write/read, back-to-back at both address extremes, untouched location
        do_write(4'd3, 8'hA5);
        do_read(4'd3, 8'hA5);
        do_write(4'd0, 8'h11);
        do_write(4'd15, 8'h22);
        do_read(4'd0, 8'h11);
        do_read(4'd15, 8'h22);
        do_read(4'd4, 8'h84);

        // req_valid held high: W5, R5, W6, R6 with 2/3-cycle cadence
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 8'h31;
        step();
        chk("st_w0_strobe", sram_w_r, 1'b1);
        step();
        chk("st_w0_ready", req_ready, 1'b1);
        req_we = 1'b0;
        step();
        chk("st_r0_addr", sram_addr, 4'd5);
        step();
        chk("st_r0_busy", req_ready, 1'b0);
        step();
        chk("st_r0_rsp", rsp_valid, 1'b1);
        chk("st_r0_data", rsp_rdata, 8'h31);
        chk("st_r0_ready", req_ready, 1'b1);
        req_we = 1'b1; req_addr = 4'd6; req_wdata = 8'h42;
        step();
        chk("st_w1_strobe", sram_w_r, 1'b1);
        chk("st_w1_addr", sram_addr, 4'd6);
        chk("st_w1_rsp_low", rsp_valid, 1'b0);
        step();
        chk("st_w1_ready", req_ready, 1'b1);
        req_we = 1'b0;
        step();
        step();
        step();
        chk("st_r1_rsp", rsp_valid, 1'b1);
        chk("st_r1_data", rsp_rdata, 8'h42);
        req_valid = 1'b0;
        step();
        chk("st_idle_ready", req_ready, 1'b1);
        chk("st_idle_rsp", rsp_valid, 1'b0);
        exp_rsp += 2;

        // reset while a read is in flight
        do_write(4'd9, 8'h77);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
        step();
        req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rrd_ready", req_ready, 1'b1);
        chk("rrd_strobe", sram_w_r, 1'b0);
        chk("rrd_addr", sram_addr, 4'd0);
        chk("rrd_rsp0", rsp_valid, 1'b0);
        step();
        chk("rrd_rsp1", rsp_valid, 1'b0);
        step();
        chk("rrd_rsp2", rsp_valid, 1'b0);
        do_read(4'd9, 8'h77);

        // reset on the WR edge: write still lands
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd7; req_wdata = 8'h5C;
        step();
        chk("rwr_strobe", sram_w_r, 1'b1);
        req_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rwr_strobe_low", sram_w_r, 1'b0);
        chk("rwr_ready", req_ready, 1'b1);
        do_read(4'd7, 8'h5C);
`endif
        chk("rsp_count", rsp_cnt, exp_rsp);
        chk("bus_clean", bus_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
